// File: rtl/pasaaltas_5k.sv
// pasaaltas_5k: 2nd-order Butterworth high-pass (fc 5 kHz @ fs 44.1 kHz),
// Direct Form I, one shared 25x18 multiplier.
// Q8.16 samples, Q.16 coefficients, 48-bit accumulator.
// Sequence: IDLE -> MAC (5 cycles, one product each) -> OUT -> IDLE.
// The output register loads one cycle after OUT, so y and rx_2 change
// together 7 edges after the capturing edge.
// Build option: define PASAALTAS_SAT_EN to saturate the result to 25 bits.
// Otherwise the result wraps.
module pasaaltas_5k (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [24:0] u,
  output logic        rx_2,
  output logic [24:0] y
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [17:0] C_B0  =  18'sd39369;
  localparam logic signed [17:0] C_B1  = -18'sd78738;
  localparam logic signed [17:0] C_B2  =  18'sd39369;
  localparam logic signed [17:0] C_A1N =  18'sd67838;
  localparam logic signed [17:0] C_A2N = -18'sd24104;

  state_t             r_state, w_next;
  logic [2:0]         r_cnt;
  logic signed [24:0] r_u0, r_u1, r_u2, r_y1, r_y2;
  logic signed [47:0] r_acc;
  logic               r_out_d;
  logic [24:0]        r_y;
  logic               r_rx2;

  logic signed [24:0] w_x;
  logic signed [17:0] w_c;
  logic signed [42:0] w_prod;
  logic [47:0]        w_acc_nxt;
  logic [24:0]        w_ynew;
  logic               w_unused;

  // Next-state logic; strobes outside IDLE are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rx) w_next = MAC;
      MAC:     if (r_cnt == 3'd4) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand select: tap r_cnt picks one sample/coefficient pair.
  always_comb begin
    w_x = r_u0;
    w_c = C_B0;
    case (r_cnt)
      3'd0:    begin w_x = r_u0; w_c = C_B0;  end
      3'd1:    begin w_x = r_u1; w_c = C_B1;  end
      3'd2:    begin w_x = r_u2; w_c = C_B2;  end
      3'd3:    begin w_x = r_y1; w_c = C_A1N; end
      3'd4:    begin w_x = r_y2; w_c = C_A2N; end
      default: begin w_x = r_u0; w_c = C_B0;  end
    endcase
  end

  assign w_prod    = $signed({{18{w_x[24]}}, w_x}) * $signed({{25{w_c[17]}}, w_c});
  assign w_acc_nxt = r_acc + {{5{w_prod[42]}}, w_prod};

  // Drop 16 fraction bits (floor), then clamp or wrap to 25 bits.
`ifdef PASAALTAS_SAT_EN
  always_comb begin
    w_ynew = r_acc[40:16];
    if (!r_acc[47] && (r_acc[46:40] != 7'h00))      w_ynew = 25'h0FFFFFF;
    else if (r_acc[47] && (r_acc[46:40] != 7'h7F))  w_ynew = 25'h1000000;
  end
  assign w_unused = ^r_acc[15:0];
`else
  assign w_ynew   = r_acc[40:16];
  assign w_unused = ^{r_acc[47:41], r_acc[15:0]};
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Datapath: capture the sample, accumulate products, shift the delay lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_u0  <= '0;
      r_u1  <= '0;
      r_u2  <= '0;
      r_y1  <= '0;
      r_y2  <= '0;
    end else begin
      case (r_state)
        IDLE: if (rx) begin
          r_u0  <= u;
          r_acc <= '0;
          r_cnt <= '0;
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 3'd1;
        end
        OUT: begin
          r_u2 <= r_u1;
          r_u1 <= r_u0;
          r_y2 <= r_y1;
          r_y1 <= w_ynew;
        end
        default: ;
      endcase
    end
  end

  // Output stage: publish the new y with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_d <= 1'b0;
      r_y     <= '0;
      r_rx2   <= 1'b0;
    end else begin
      r_out_d <= (r_state == OUT);
      r_rx2   <= r_out_d;
      if (r_out_d) r_y <= r_y1;
    end
  end

  assign y    = r_y;
  assign rx_2 = r_rx2;

endmodule

// File: tb/tb_pasaaltas_5k.sv
// tb_pasaaltas_5k: scoreboard bench for pasaaltas_5k.
// Expected y values come from a behavioural DF-I model.
// A monitor pops and compares them on each rx_2 strobe.
module tb_pasaaltas_5k;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [24:0] u;
  logic        rx_2;
  logic [24:0] y;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_rx2  = 0;

  longint q_exp[$];
  int     q_cap[$];
  longint obs[$];

  longint m_u1, m_u2, m_y1, m_y2;

  pasaaltas_5k dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .u   (u),
    .rx_2(rx_2),
    .y   (y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint model(input longint x);
    longint acc, s;
    acc = 39369 * x - 78738 * m_u1 + 39369 * m_u2 + 67838 * m_y1 - 24104 * m_y2;
    s   = acc >>> 16;
`ifdef PASAALTAS_SAT_EN
    if (s > 16777215) s = 16777215;
    else if (s < -16777216) s = -16777216;
`else
    s = s & 64'h1FFFFFF;
    if (s >= 16777216) s = s - 33554432;
`endif
    m_u2 = m_u1;
    m_u1 = x;
    m_y2 = m_y1;
    m_y1 = s;
    return s;
  endfunction

  task automatic model_clear();
    m_u1 = 0; m_u2 = 0; m_y1 = 0; m_y2 = 0;
    q_exp.delete();
    q_cap.delete();
  endtask

  // One accepted strobe, then idle until gap cycles have elapsed.
  task automatic send(input logic [24:0] val, input int gap);
    @(negedge clk);
    rx = 1'b1;
    u  = val;
    q_exp.push_back(model(longint'($signed(val))));
    q_cap.push_back(cyc + 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Monitor: every rx_2 strobe must match the oldest expected sample.
  always @(negedge clk) begin
    longint e;
    int     c;
    if (rst && rx_2) begin
      n_rx2++;
      obs.push_back(longint'($signed(y)));
      if (q_exp.size() == 0) begin
        chk("spurious_rx2", 1, 0);
      end else begin
        e = q_exp.pop_front();
        c = q_cap.pop_front();
        chk("y", longint'($signed(y)), e);
        chk("latency", longint'(cyc - c), 7);
      end
    end
  end

  initial begin
    int     p0, nbad, hits;
    longint a;
    rst = 1'b0; rx = 1'b0; u = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_y", longint'(y), 0);
    chk("rst_rx2", longint'(rx_2), 0);
    rst = 1'b1;
    @(negedge clk);

    // Impulse from zero history.
    obs.delete();
    send(25'd65536, 8); send(25'd0, 8); send(25'd0, 8);
    repeat (4) @(negedge clk);
    chk("imp_count", obs.size(), 3);
    if (obs.size() >= 2) begin
      chk("imp0", obs[0], 39369);
      chk("imp1", obs[1], -37987);
    end

    // DC step: output must settle to within 2 LSB.
    obs.delete();
    for (int i = 0; i < 200; i++) send(25'd65536, 8);
    repeat (4) @(negedge clk);
    nbad = 0;
    for (int i = 100; i < obs.size(); i++) begin
      a = obs[i]; if (a < 0) a = -a;
      if (a > 2) nbad++;
    end
    chk("dc_count", obs.size(), 200);
    chk("dc_settle", nbad, 0);

    // Nyquist: steady-state amplitude within 1 % of 65536.
    obs.delete();
    for (int i = 0; i < 80; i++) send((i % 2 == 0) ? 25'd65536 : 25'h1FF0000, 8);
    repeat (4) @(negedge clk);
    nbad = 0;
    for (int i = 60; i < obs.size(); i++) begin
      a = obs[i]; if (a < 0) a = -a;
      if (a < 64881 || a > 66191) nbad++;
    end
    chk("nyq_count", obs.size(), 80);
    chk("nyq_gain", nbad, 0);

    // Strobe re-asserted 3 cycles into a computation is ignored.
    p0 = n_rx2;
    @(negedge clk);
    rx = 1'b1; u = 25'd65536;
    q_exp.push_back(model(65536));
    q_cap.push_back(cyc + 1);
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1; u = 25'd12345;
    @(negedge clk); rx = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore_one_pulse", n_rx2 - p0, 1);

    // Reset in the middle of MAC aborts the sample.
    @(negedge clk);
    rx = 1'b1; u = 25'd65536;
    @(negedge clk); rx = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_y", longint'(y), 0);
    chk("abort_rx2", longint'(rx_2), 0);
    model_clear();
    p0 = n_rx2;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_pulse", n_rx2 - p0, 0);
    obs.delete();
    send(25'd65536, 8); send(25'd0, 8);
    repeat (4) @(negedge clk);
    chk("reimp_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("reimp0", obs[0], 39369);
      chk("reimp1", obs[1], -37987);
    end

    // Full-scale alternating input: saturation or wrap per build.
    obs.delete();
    for (int i = 0; i < 40; i++) send((i % 2 == 0) ? 25'h0FFFFFF : 25'h1000000, 8);
    repeat (4) @(negedge clk);
    chk("fs_count", obs.size(), 40);
`ifdef PASAALTAS_SAT_EN
    hits = 0;
    for (int i = 0; i < obs.size(); i++)
      if (obs[i] == 16777215 || obs[i] == -16777216) hits++;
    chk("fs_clamp_seen", longint'(hits > 0), 1);
`else
    hits = 0;
`endif

    chk("drain", q_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pasaaltas_5k.md
PASAALTAS_5K -- requirements
Module: pasaaltas_5k

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 25 bits and coefficients are fixed constants.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 rx  input  1  sample strobe; a one-cycle pulse marks u as a new input sample.
REQ-005 u  input  25  input sample, signed two's complement Q8.16 (1 sign, 8 integer, 16 fraction bits).
REQ-006 rx_2  output  1  output strobe; a one-cycle pulse marks y as a new filtered sample.
REQ-007 y  output  25  filtered output sample, signed Q8.16, registered.

Function
REQ-008 The block SHALL implement a 2nd-order Butterworth high-pass, fc = 5 kHz at fs = 44.1 kHz, in Direct Form I.
- y[n] = b0·u[n] + b1·u[n-1] + b2·u[n-2] + a1n·y[n-1] + a2n·y[n-2].
REQ-009 Coefficients SHALL be signed Q.16 integers:
- b0 = 39369, b1 = -78738, b2 = 39369.
- a1n = +67838, a2n = -24104.
- b0+b1+b2 = 0, so DC gain is exactly zero.
REQ-010 All five 25x18-bit products SHALL be summed at full precision in a signed accumulator of at least 46 bits.
- The sum SHALL then be arithmetic-shifted right by 16, truncating toward minus infinity.
- The result SHALL be reduced to 25 bits per REQ-020/021.
REQ-011 The block SHALL use a sequential FSM with states IDLE, MAC (5 cycles, one product per cycle), OUT.
REQ-012 IDLE→MAC on a clock edge where rx=1; u SHALL be captured on that edge.
REQ-013 rx_2 SHALL pulse high for exactly one cycle, 7 clock edges after the capturing edge.
- The new y SHALL be valid in that same cycle and hold until the next update.
- Total latency of 7 cycles is within the 15-cycle budget.
REQ-014 On the OUT cycle, the delay lines SHALL shift (u2←u1, u1←u, y2←y1, y1←new y); the FSM then SHALL return to IDLE.
REQ-015 An rx pulse while not in IDLE SHALL be ignored: no capture, no effect on the computation in progress.
REQ-016 Back-to-back strobes 8 or more cycles apart SHALL each produce exactly one rx_2 pulse.

Reset
REQ-017 While rst=0, the following SHALL be cleared asynchronously: y=0, rx_2=0, FSM=IDLE, accumulator and all four delay registers = 0.
REQ-018 A computation in progress when reset asserts SHALL be aborted with no rx_2 pulse.
REQ-019 The first rx after reset release SHALL be processed normally, with zero filter history.

Configuration
REQ-020 With macro PASAALTAS_SAT_EN defined, the shifted sum SHALL saturate to the range [-16777216, 16777215] before being stored to y and y1.
REQ-021 Without PASAALTAS_SAT_EN, the low 25 bits of the shifted sum SHALL be used (two's-complement wrap).

Verification
REQ-022 Reset then impulse: u=65536 (1.0), then u=0 on following strobes:
- 1st y = 39369 (0x00099C9).
- 2nd y = -37987 (0x1FF6B9D).
- rx_2 pulses 7 cycles after each rx.
REQ-023 DC step: u=65536 held for 200 strobes → |y| ≤ 2 LSB after 100 strobes.
REQ-024 Nyquist input: u alternating +65536/-65536 → steady-state |y| within 1% of 65536.
REQ-025 rx re-asserted 3 cycles after a strobe:
- Second rx ignored; exactly one rx_2 pulse.
- y matches the single-sample model.
REQ-026 rst asserted during MAC:
- Outputs zero immediately; no rx_2 pulse.
- The next impulse reproduces the REQ-022 values.
REQ-027 Full-scale input u=0x0FFFFFF then 0x1000000 alternating:
- With PASAALTAS_SAT_EN, y clamps to 16777215 / -16777216.
- Without it, y equals the bit-exact wrapped model.
